hld_rd_credit_gate: RTL and testbench

- Single-clock stage between the multi-channel read arbiter output and the SPL/CCI read interface, in the `clk` domain.
- Caps the number of in-flight read requests to a programmable credit limit, so SPL read responses never overrun the per-port async response FIFOs. This keeps SPL back-pressure from being needed.
- Registers both the request and response paths for timing.
- Exports outstanding-count, idle and error status to the shim's done/drain logic.

---
 rtl/hld_rd_credit_pkg.sv | 18 +
 rtl/hld_skid_buffer.sv | 64 ++++++
 rtl/hld_rd_credit_gate.sv | 116 +++++++++++
 tb/tb_hld_rd_credit_gate.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hld_rd_credit_pkg.sv
// Shared definitions for the read-request credit gate.
// Contents:
//   REQ_WIDTH_DEF, RESP_WIDTH_DEF : default request / response payload widths
//   MAX_OUTSTANDING_DEF           : default ceiling on in-flight reads
//   clamp_limit()                 : effective limit = min(requested, ceiling)
package hld_rd_credit_pkg;

    localparam int REQ_WIDTH_DEF       = 80;
    localparam int RESP_WIDTH_DEF      = 528;
    localparam int MAX_OUTSTANDING_DEF = 64;

    // A runtime limit larger than the hardware ceiling is treated as the ceiling.
    function automatic int unsigned clamp_limit(input int unsigned limit,
                                                input int unsigned ceiling);
        return (limit > ceiling) ? ceiling : limit;
    endfunction

endpackage

// File: rtl/hld_skid_buffer.sv
// Two-entry skid buffer with valid/ready on both sides.
// in_ready depends only on registered occupancy, so there is no combinational
// path from out_ready back to in_ready.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side (out_data is the head register)
//   level                 : current occupancy (0..2), exported for status/debug
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high; a held valid keeps its data stable until then.
module hld_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign level     = count;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Push and pop together can only occur with one entry held
                // (push is blocked when full, pop needs an entry), so the new
                // word simply replaces the departing head.
                2'b11: head <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hld_rd_credit_gate.sv
// Read-request credit gate between the read arbiter and the SPL/CCI read port.
// Limits in-flight reads to min(credit_limit, MAX_OUTSTANDING) so read
// responses can never overrun the downstream response FIFOs.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   credit_limit                      : runtime in-flight limit (clamped)
//   in_req_*  / out_req_*             : request path, 2-entry skid buffer
//   in_resp_* / out_resp_*            : response path, one register stage
//   outstanding                       : reads accepted but not yet answered
//   idle                              : nothing in flight, both outputs empty
//   err_underflow                     : sticky, response seen with nothing in flight
// Handshake rule (all four interfaces): a transfer happens on a rising edge
// where valid and ready are both high; a held valid keeps its data stable.
module hld_rd_credit_gate
    import hld_rd_credit_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter  int REQ_WIDTH       = REQ_WIDTH_DEF,
    parameter  int RESP_WIDTH      = RESP_WIDTH_DEF,
    localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  credit_limit,
    input  logic                  in_req_valid,
    output logic                  in_req_ready,
    input  logic [REQ_WIDTH-1:0]  in_req_data,
    output logic                  out_req_valid,
    input  logic                  out_req_ready,
    output logic [REQ_WIDTH-1:0]  out_req_data,
    input  logic                  in_resp_valid,
    output logic                  in_resp_ready,
    input  logic [RESP_WIDTH-1:0] in_resp_data,
    output logic                  out_resp_valid,
    input  logic                  out_resp_ready,
    output logic [RESP_WIDTH-1:0] out_resp_data,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  idle,
    output logic                  err_underflow
);

    logic [CNT_WIDTH-1:0] lim;
    logic                 credit_avail;
    logic                 skid_in_valid;
    logic                 skid_in_ready;
    logic [1:0]           skid_level;
    logic                 req_hs;
    logic                 resp_hs;

    assign lim = CNT_WIDTH'(clamp_limit(32'(credit_limit), 32'(MAX_OUTSTANDING)));

    // Credit check uses only the registered count: a response returning a
    // credit this cycle re-opens the request side one cycle later, which
    // keeps the response path out of the request-ready timing path.
    assign credit_avail = (outstanding < lim);

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    assign in_req_ready  = ~rst & skid_in_ready & credit_avail;
    assign skid_in_valid = ~rst & in_req_valid & credit_avail;
    assign req_hs        = in_req_valid & in_req_ready;

    hld_skid_buffer #(
        .WIDTH (REQ_WIDTH)
    ) u_req_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (in_req_data),
        .out_valid (out_req_valid),
        .out_ready (out_req_ready),
        .out_data  (out_req_data),
        .level     (skid_level)
    );

    // ------------------------------------------------------------------
    // Response path: single register stage, full throughput
    // ------------------------------------------------------------------
    assign in_resp_ready = ~rst & (~out_resp_valid | out_resp_ready);
    assign resp_hs       = in_resp_valid & in_resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_resp_valid <= 1'b0;
            out_resp_data  <= '0;
        end else if (in_resp_ready) begin
            out_resp_valid <= in_resp_valid;
            if (in_resp_valid) out_resp_data <= in_resp_data;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counter and underflow flag
    // ------------------------------------------------------------------
    // Increments are bounded by credit_avail, so the count cannot pass the
    // ceiling; a response with nothing in flight leaves the count at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (resp_hs && (outstanding == '0)) err_underflow <= 1'b1;

            if (req_hs && !resp_hs) begin
                outstanding <= outstanding + CNT_WIDTH'(1);
            end else if (resp_hs && !req_hs && (outstanding != '0)) begin
                outstanding <= outstanding - CNT_WIDTH'(1);
            end
        end
    end

    assign idle = ~rst & (outstanding == '0) & (skid_level == 2'd0) & ~out_resp_valid;

endmodule

// File: tb/tb_hld_rd_credit_gate.sv
// Self-checking bench for hld_rd_credit_gate: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference
// model (request/response queues plus an in-flight count).
module tb_hld_rd_credit_gate;

    localparam int MAXO   = 64;
    localparam int REQ_W  = 80;
    localparam int RESP_W = 528;
    localparam int CW     = $clog2(MAXO) + 1;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     credit_limit;
    logic              in_req_valid;
    logic              in_req_ready;
    logic [REQ_W-1:0]  in_req_data;
    logic              out_req_valid;
    logic              out_req_ready;
    logic [REQ_W-1:0]  out_req_data;
    logic              in_resp_valid;
    logic              in_resp_ready;
    logic [RESP_W-1:0] in_resp_data;
    logic              out_resp_valid;
    logic              out_resp_ready;
    logic [RESP_W-1:0] out_resp_data;
    logic [CW-1:0]     outstanding;
    logic              idle;
    logic              err_underflow;

    always #5 clk = ~clk;

    hld_rd_credit_gate #(
        .MAX_OUTSTANDING (MAXO),
        .REQ_WIDTH       (REQ_W),
        .RESP_WIDTH      (RESP_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .credit_limit   (credit_limit),
        .in_req_valid   (in_req_valid),
        .in_req_ready   (in_req_ready),
        .in_req_data    (in_req_data),
        .out_req_valid  (out_req_valid),
        .out_req_ready  (out_req_ready),
        .out_req_data   (out_req_data),
        .in_resp_valid  (in_resp_valid),
        .in_resp_ready  (in_resp_ready),
        .in_resp_data   (in_resp_data),
        .out_resp_valid (out_resp_valid),
        .out_resp_ready (out_resp_ready),
        .out_resp_data  (out_resp_data),
        .outstanding    (outstanding),
        .idle           (idle),
        .err_underflow  (err_underflow)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int                n_tests = 0;
    int                n_fail  = 0;
    logic [REQ_W-1:0]  exp_q[$];   // accepted requests not yet taken by SPL
    logic [RESP_W-1:0] resp_q[$];  // accepted responses not yet taken by arbiter
    int                m_cnt;      // reads in flight
    bit                m_err;      // sticky underflow
    logic [REQ_W-1:0]  cur_req;
    logic [RESP_W-1:0] cur_resp;
    int                sent_cnt;

    task automatic chk(input string tag, input logic [RESP_W-1:0] obs,
                       input logic [RESP_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] rand_req();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[REQ_W-1:0];
    endfunction

    function automatic logic [RESP_W-1:0] rand_resp();
        logic [543:0] r;
        for (int k = 0; k < 17; k++) r[k*32 +: 32] = $urandom;
        return r[RESP_W-1:0];
    endfunction

    function automatic int m_lim();
        int l;
        l = int'(credit_limit);
        return (l > MAXO) ? MAXO : l;
    endfunction

    function automatic bit m_req_ready();
        return !rst && (exp_q.size() < 2) && (m_cnt < m_lim());
    endfunction

    task automatic check_state(input bit osr);
        chk("in_req_ready", RESP_W'(in_req_ready), RESP_W'(m_req_ready()));
        chk("out_req_valid", RESP_W'(out_req_valid), RESP_W'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("out_req_data", RESP_W'(out_req_data), RESP_W'(exp_q[0]));
        chk("out_resp_valid", RESP_W'(out_resp_valid), RESP_W'(resp_q.size() > 0));
        if (resp_q.size() > 0) chk("out_resp_data", out_resp_data, resp_q[0]);
        chk("in_resp_ready", RESP_W'(in_resp_ready),
            RESP_W'(!rst && (resp_q.size() == 0 || osr)));
        chk("outstanding", RESP_W'(outstanding), RESP_W'(m_cnt));
        chk("idle", RESP_W'(idle),
            RESP_W'(!rst && m_cnt == 0 && exp_q.size() == 0 && resp_q.size() == 0));
        chk("err_underflow", RESP_W'(err_underflow), RESP_W'(m_err));
    endtask

    task automatic check_reset_values();
        chk("rst_out_req_valid", RESP_W'(out_req_valid), RESP_W'(1'b0));
        chk("rst_out_resp_valid", RESP_W'(out_resp_valid), RESP_W'(1'b0));
        chk("rst_outstanding", RESP_W'(outstanding), RESP_W'(0));
        chk("rst_err_underflow", RESP_W'(err_underflow), RESP_W'(1'b0));
        chk("rst_idle", RESP_W'(idle), RESP_W'(1'b0));
        chk("rst_in_req_ready", RESP_W'(in_req_ready), RESP_W'(1'b0));
        chk("rst_in_resp_ready", RESP_W'(in_resp_ready), RESP_W'(1'b0));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks. Entered 1 time unit after a rising edge; inputs are
    // applied, outputs sampled one unit later, then the model advances.
    // ------------------------------------------------------------------
    task automatic cycle(input bit rqv, input bit orr, input bit rsv, input bit osr);
        bit req_hs, oreq_hs, resp_hs, oresp_hs;
        in_req_valid   = rqv;
        in_req_data    = cur_req;
        out_req_ready  = orr;
        in_resp_valid  = rsv;
        in_resp_data   = cur_resp;
        out_resp_ready = osr;
        #1;
        check_state(osr);
        if (out_req_valid && orr) sent_cnt++;
        req_hs   = rqv && m_req_ready();
        oreq_hs  = (exp_q.size() > 0) && orr;
        resp_hs  = rsv && !rst && (resp_q.size() == 0 || osr);
        oresp_hs = (resp_q.size() > 0) && osr;
        @(posedge clk);
        if (oreq_hs) void'(exp_q.pop_front());
        if (req_hs) begin
            exp_q.push_back(cur_req);
            cur_req = rand_req();
        end
        if (oresp_hs) void'(resp_q.pop_front());
        if (resp_hs) begin
            resp_q.push_back(cur_resp);
            cur_resp = rand_resp();
        end
        if (resp_hs && m_cnt == 0) m_err = 1'b1;
        if (req_hs && !resp_hs) m_cnt++;
        else if (resp_hs && !req_hs && m_cnt > 0) m_cnt--;
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        resp_q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        in_req_valid  = 1'b0;
        in_resp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence followed by random traffic
    // ------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        credit_limit   = '0;
        in_req_valid   = 1'b0;
        in_req_data    = '0;
        out_req_ready  = 1'b0;
        in_resp_valid  = 1'b0;
        in_resp_data   = '0;
        out_resp_ready = 1'b0;
        m_cnt          = 0;
        m_err          = 1'b0;
        sent_cnt       = 0;
        cur_req        = rand_req();
        cur_resp       = rand_resp();
        #2;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Limit 4, SPL always ready, 10 cycles of offered requests.
        credit_limit = CW'(4);
        sent_cnt = 0;
        repeat (10) cycle(1, 1, 0, 1);
        chk("t1_sent", RESP_W'(sent_cnt), RESP_W'(4));
        chk("t1_outstanding", RESP_W'(outstanding), RESP_W'(4));
        chk("t1_in_req_ready", RESP_W'(in_req_ready), RESP_W'(1'b0));

        // From full, one response: request side re-opens only a cycle later.
        cycle(1, 1, 1, 1);
        chk("t2_outstanding_3", RESP_W'(outstanding), RESP_W'(3));
        chk("t2_reopen", RESP_W'(in_req_ready), RESP_W'(1'b1));
        cycle(1, 1, 0, 1);
        chk("t2_outstanding_4", RESP_W'(outstanding), RESP_W'(4));

        // Down to 2, then simultaneous request and response handshakes.
        repeat (2) cycle(0, 1, 1, 1);
        chk("t3_outstanding_2", RESP_W'(outstanding), RESP_W'(2));
        cycle(1, 1, 1, 1);
        chk("t3_same_cycle", RESP_W'(outstanding), RESP_W'(2));
        repeat (3) cycle(0, 1, 0, 1);

        // SPL stalls with two requests pending in the skid buffer.
        credit_limit = CW'(8);
        repeat (7) cycle(1, 0, 0, 1);
        chk("t4_skid_full", RESP_W'(in_req_ready), RESP_W'(1'b0));
        sent_cnt = 0;
        repeat (3) cycle(0, 1, 0, 1);
        chk("t4_sent", RESP_W'(sent_cnt), RESP_W'(2));

        // Raise to 6 in flight, then cut the limit to 2.
        repeat (2) cycle(1, 1, 0, 1);
        repeat (2) cycle(0, 1, 0, 1);
        chk("t5_outstanding_6", RESP_W'(outstanding), RESP_W'(6));
        credit_limit = CW'(2);
        repeat (5) cycle(1, 1, 1, 1);
        chk("t5_outstanding_1", RESP_W'(outstanding), RESP_W'(1));
        repeat (4) cycle(1, 1, 0, 1);
        chk("t5_capped", RESP_W'(outstanding), RESP_W'(2));
        chk("t5_blocked", RESP_W'(in_req_ready), RESP_W'(1'b0));

        // Limit 0: drain everything, then a stray response underflows.
        credit_limit = CW'(0);
        repeat (2) cycle(1, 1, 1, 1);
        repeat (2) cycle(1, 1, 0, 1);
        chk("t6_idle", RESP_W'(idle), RESP_W'(1'b1));
        cycle(0, 1, 1, 1);
        chk("t6_err_set", RESP_W'(err_underflow), RESP_W'(1'b1));
        chk("t6_outstanding_0", RESP_W'(outstanding), RESP_W'(0));
        repeat (3) cycle(0, 1, 0, 1);
        chk("t6_err_sticky", RESP_W'(err_underflow), RESP_W'(1'b1));

        // Limit above the ceiling clamps to MAXO.
        credit_limit = CW'(127);
        repeat (MAXO + 6) cycle(1, 1, 0, 1);
        chk("t7_clamp", RESP_W'(outstanding), RESP_W'(MAXO));
        chk("t7_clamp_block", RESP_W'(in_req_ready), RESP_W'(1'b0));

        // Random traffic with a reset pulse in the middle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) credit_limit = CW'($urandom_range(0, 127));
            if (i == 200) reset_pulse();
            cycle(bit'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0,
                  (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
